// File: rtl/data_memory_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory responder.
interface data_memory_responder_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  modport slave (
    input  mem_read_i, mem_write_i, addr_i, wdata_i,
    output rdata_o, stall_o, done_o, err_o
  );

  modport master (
    output mem_read_i, mem_write_i, addr_i, wdata_i,
    input  rdata_o, stall_o, done_o, err_o
  );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory: latches a MEM-stage request, stalls the pipeline for LATENCY
// BUSY cycles, then performs the access and pulses done for one cycle.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                    clock_i,
  input  logic                    rst_n_i,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            is_write_q, is_write_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req;
  logic            access;
  logic [31:0]     mem [DEPTH_WORDS];

  // Upper address bits alias onto the same words by design.
  logic unused_addr;
  assign unused_addr = ^bus.addr_i[31:IdxW+2];

  assign req = bus.mem_read_i | bus.mem_write_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    access     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StBusy;
          cnt_d      = 4'(LATENCY - 1);
          idx_d      = bus.addr_i[IdxW+1:2];
          wdata_d    = bus.wdata_i;
          // A simultaneous read+write is treated as a write.
          is_write_d = bus.mem_write_i;
          if ((bus.addr_i[1:0] != 2'b00) || (bus.mem_read_i && bus.mem_write_i)) begin
            err_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StDone;
          if (!is_write_q) begin
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      is_write_q <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not reset; an asynchronous reset aborts BUSY before this edge.
  always_ff @(posedge clock_i) begin
    if (access && is_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.stall_o = rst_n_i & (((state_q == StIdle) & req) | (state_q == StBusy));
  assign bus.done_o  = (state_q == StDone);
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;

endmodule
